alu_inv: RTL
============

Name: alu_inv

Overview:
- Sequential inverse of the team's 4-bit ALU: recovers operand a from an ALU result z, operand b and op select sel.
- Used on the checking/recovery side of ALU datapaths.
- Add, sub and xor inverses resolve in one cycle.
- Mul inverse uses an iterative restoring divider.
- Every result carries a consistency/error code.
- Valid/ready handshake on both input and output; one transaction in flight.

Parameters:
WIDTH, 4, operand width; z is 2*WIDTH bits; divider runs 2*WIDTH iterations

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
z  in  2*WIDTH  ALU result to invert
b  in  WIDTH  known operand b
sel  in  2  op: 00 add, 01 sub, 10 mul, 11 xor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
a  out  WIDTH  recovered operand a
err_code  out  2  00 ok, 01 out of range, 10 nonzero remainder, 11 divide by zero

Behaviour:
- Interface fixed: one clock clk; reset rst_n is synchronous and active-low.
- Reset, rst_n low at a clk edge, whatever the state (mid-divide included):
  - state goes to IDLE; out_valid=0, a=0, err_code=00, divider regs cleared.
  - in_ready=0 while rst_n is low.
  - in_ready=1 on the first edge with rst_n high.
- FSM states: IDLE, DIV, DONE. All outputs are registered.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid&in_ready; capture z, b, sel.
  - If sel=10 and b!=0: go to DIV, iteration count=0, remainder=0, quotient=z.
  - Otherwise compute the result, load a/err_code, go to DONE.
- Arithmetic, all modulo 2^(2*WIDTH) unless stated:
  - add: d=z-b; a=d[WIDTH-1:0]; err 01 if z<b or d>2^WIDTH-1.
  - sub: s=(z+b) mod 2^(2*WIDTH); a=s[WIDTH-1:0]; err 01 if s>2^WIDTH-1.
  - xor: a=z[WIDTH-1:0]^b; err 01 if z[2*WIDTH-1:WIDTH]!=0.
  - mul with b=0: a=0, err 11, no DIV cycles.
  - mul with b!=0: restoring division, one quotient bit per cycle, MSB first, 2*WIDTH cycles in DIV.
    - Final quotient q, remainder r; a=q[WIDTH-1:0].
    - err 01 if q>2^WIDTH-1, else 10 if r!=0, else 00. Code 01 has priority over 10.
- Latency:
  - Non-mul and div-by-zero: out_valid rises 1 cycle after accept.
  - mul with b!=0: out_valid rises 2*WIDTH+1 cycles after accept (9 for WIDTH=4).
- DIV: in_ready=0; inputs ignored; after the last iteration load a/err_code and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - a/err_code stable until out_valid&out_ready.
  - On handshake: out_valid=0 next cycle, return to IDLE.
  - No same-cycle output handshake + new accept; max throughput one request per 2 cycles (non-mul).
- sel is 2 bits; all codes defined, no default path.

Test Plan:
- add: z=8'h1E, b=4'hF, sel=00 -> a=4'hF, err=00, out_valid 1 cycle after accept. Then z=8'h03, b=4'h5 -> err=01.
- sub wrap: z=8'hFD, b=4'h5, sel=01 -> a=4'h2, err=00. Then z=8'h20, b=4'h1 -> err=01, a=4'h1.
- mul exact: z=8'h8F, b=4'hD, sel=10 -> a=4'hB, err=00, out_valid exactly 9 cycles after accept. Then z=8'h64, b=4'h7 -> a=4'hE, err=10. Then z=8'hE1, b=4'h1 -> a=4'h1, err=01 (priority over remainder).
- div by zero: z=8'h10, b=0, sel=10 -> a=0, err=11, out_valid 1 cycle after accept.
- xor: z=8'h06, b=4'hA, sel=11 -> a=4'hC, err=00. Then z=8'h16, b=4'hA -> a=4'hC, err=01.
- backpressure/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> a/err_code/out_valid stable, in_ready=0, new in_valid ignored.
  - Drive rst_n=0 during cycle 4 of DIV -> next edge out_valid=0, a=0; in_ready=1 after release; a fresh add request completes normally.

Source files
------------

// File: rtl/alu_inv_if.sv
// Request/response bundle for the ALU inverse: request side (z, b, sel) and
// the recovered operand with its consistency code.
interface alu_inv_if #(parameter int WIDTH = 4);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   z;
    logic [WIDTH-1:0]     b;
    logic [1:0]           sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     a;
    logic [1:0]           err_code;

    modport master (
        output in_valid, z, b, sel, out_ready,
        input  in_ready, out_valid, a, err_code
    );

    modport slave (
        input  in_valid, z, b, sel, out_ready,
        output in_ready, out_valid, a, err_code
    );
endinterface

// File: rtl/alu_inv.sv
// Recovers ALU operand a from result z, operand b and op select; add/sub/xor
// resolve in one cycle, mul is undone with a restoring divider.
module alu_inv #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_inv_if.slave bus
);
    // state | meaning
    // IDLE  | ready for a request
    // DIV   | restoring division, one quotient bit per cycle
    // DONE  | result held until the consumer takes it
    localparam int ZW = 2 * WIDTH;
    localparam int CW = $clog2(ZW);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OOR = 2'b01;
    localparam logic [1:0] ERR_REM = 2'b10;
    localparam logic [1:0] ERR_DZ  = 2'b11;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t             r_state,     w_state_nxt;
    logic               r_in_ready,  w_in_ready_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0]   r_a,         w_a_nxt;
    logic [1:0]         r_err,       w_err_nxt;
    logic [WIDTH-1:0]   r_rem,       w_rem_nxt;
    logic [ZW-1:0]      r_quo,       w_quo_nxt;
    logic [WIDTH-1:0]   r_b,         w_b_nxt;
    logic [CW-1:0]      r_cnt,       w_cnt_nxt;

    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_step;
    logic [ZW-1:0]      w_quo_step;
    logic [ZW-1:0]      w_bz;
    logic [ZW-1:0]      w_diff;
    logic [ZW-1:0]      w_sum;

    // Remainder stays below b, so WIDTH bits suffice; the shifted value needs one more.
    assign w_rem_sh   = {r_rem, r_quo[ZW-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
    assign w_rem_step = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_step = {r_quo[ZW-2:0], w_ge};

    assign w_bz   = {{WIDTH{1'b0}}, bus.b};
    assign w_diff = bus.z - w_bz;
    assign w_sum  = bus.z + w_bz;

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_err_nxt   = r_err;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_b_nxt     = r_b;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_state_nxt = DONE;
                    case (bus.sel)
                        2'b00: begin
                            w_a_nxt   = w_diff[WIDTH-1:0];
                            w_err_nxt = ((bus.z < w_bz) || (w_diff[ZW-1:WIDTH] != '0)) ? ERR_OOR : ERR_OK;
                        end
                        2'b01: begin
                            w_a_nxt   = w_sum[WIDTH-1:0];
                            w_err_nxt = (w_sum[ZW-1:WIDTH] != '0) ? ERR_OOR : ERR_OK;
                        end
                        2'b10: begin
                            if (bus.b == '0) begin
                                w_a_nxt   = '0;
                                w_err_nxt = ERR_DZ;
                            end else begin
                                w_state_nxt = DIV;
                                w_cnt_nxt   = '0;
                                w_rem_nxt   = '0;
                                w_quo_nxt   = bus.z;
                                w_b_nxt     = bus.b;
                            end
                        end
                        2'b11: begin
                            w_a_nxt   = bus.z[WIDTH-1:0] ^ bus.b;
                            w_err_nxt = (bus.z[ZW-1:WIDTH] != '0) ? ERR_OOR : ERR_OK;
                        end
                    endcase
                end
            end
            DIV: begin
                w_rem_nxt = w_rem_step;
                w_quo_nxt = w_quo_step;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(ZW - 1)) begin
                    w_state_nxt = DONE;
                    w_a_nxt     = w_quo_step[WIDTH-1:0];
                    if (w_quo_step[ZW-1:WIDTH] != '0)
                        w_err_nxt = ERR_OOR;
                    else if (w_rem_step != '0)
                        w_err_nxt = ERR_REM;
                    else
                        w_err_nxt = ERR_OK;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_err       <= ERR_OK;
            r_rem       <= '0;
            r_quo       <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_a         <= w_a_nxt;
            r_err       <= w_err_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_b         <= w_b_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.a         = r_a;
    assign bus.err_code  = r_err;
endmodule
